// File: rtl/ws_mac_array_param.sv
// Weight-stationary signed MAC array: ROWS x COLS stationary weights, in-block weight loader, fixed latency.
// Define WS_ARRAY_SAT_EN to clamp each accumulate step; the default build wraps modulo 2^AW.
module ws_mac_array_param #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 8,
    parameter int AW   = 16
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      w_start_i,
    input  logic [$clog2(COLS+1)-1:0] cfg_cols_i,
    input  logic                      w_valid_i,
    input  logic [COLS*DW-1:0]        w_data_i,
    input  logic                      x_valid_i,
    input  logic [COLS*DW-1:0]        x_data_i,
    input  logic                      psum_en_i,
    input  logic [ROWS*AW-1:0]        psum_i,
    input  logic                      hold_i,
    output logic [ROWS*AW-1:0]        y_o,
    output logic                      out_valid_o,
    output logic                      w_ready_o,
    output logic                      busy_o,
    output logic                      err_o
);
    localparam int CW  = $clog2(COLS + 1);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LAT = ROWS + COLS + 1;
    localparam int XD  = ROWS + COLS - 1;
    localparam int BW  = $clog2(LAT + 2);

    localparam logic [CW-1:0] COLS_C   = CW'(COLS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    if (AW < 2 * DW) begin : g_bad_aw
        $error("ws_mac_array_param: AW must be at least 2*DW");
    end

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] k_q, k_d;
    logic [BW-1:0] inflight_q, inflight_d;
    logic          err_q, err_d;

    logic signed [DW-1:0] w_q   [ROWS][COLS];
    logic signed [DW-1:0] xp_q  [XD][COLS];
    logic signed [AW-1:0] pp_q  [ROWS][ROWS];
    logic signed [AW-1:0] acc_q [ROWS][COLS];
    logic signed [AW-1:0] acc_in[ROWS][COLS];
    logic signed [AW-1:0] acc_d [ROWS][COLS];
    logic signed [AW-1:0] dk_q  [ROWS][ROWS];
    logic [LAT-1:0]       vp_q;
    logic                 out_valid_q;
    logic [ROWS*AW-1:0]   y_q;

    logic          run, accept, start_ok, beat;
    logic [CW-1:0] k_eff;

    function automatic logic signed [AW-1:0] mac_term(input logic signed [DW-1:0] w,
                                                      input logic signed [DW-1:0] x,
                                                      input logic en);
        logic signed [2*DW-1:0] p;
        p = w * x;
        return en ? AW'(p) : '0;
    endfunction

    function automatic logic signed [AW-1:0] acc_add(input logic signed [AW-1:0] a,
                                                     input logic signed [AW-1:0] b);
`ifdef WS_ARRAY_SAT_EN
        logic signed [AW:0] s;
        s = (AW+1)'(a) + (AW+1)'(b);
        if (s[AW] != s[AW-1]) return s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        return s[AW-1:0];
`else
        return a + b;
`endif
    endfunction

    assign run      = ~hold_i;
    assign accept   = x_valid_i & run & (state_q == ST_READY);
    assign start_ok = w_start_i & run & (inflight_q == '0);
    assign beat     = w_valid_i & run & (state_q == ST_LOAD) & ~start_ok;
    assign k_eff    = ((cfg_cols_i == '0) || (cfg_cols_i > COLS_C)) ? COLS_C : cfg_cols_i;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    k_d     = k_eff;
                end
            end
            ST_LOAD: begin
                if (start_ok) begin
                    cnt_d = '0;
                    k_d   = k_eff;
                end else if (beat) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign err_d = err_q | (w_start_i & run & (inflight_q != '0))
                         | (x_valid_i & run & (state_q != ST_READY));

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !out_valid_o)      inflight_d = inflight_q + 1'b1;
        else if (!accept && out_valid_o) inflight_d = inflight_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            k_q        <= COLS_C;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the weight array is reset on purpose: cleared weights are visible state after reset.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) w_q[r][c] <= '0;
        end else if (beat) begin
            for (int c = 0; c < COLS; c++) w_q[cnt_q][c] <= w_data_i[(COLS-1-c)*DW +: DW];
        end
    end

    // PE(r,c) fires r+c+1 steps after accept; x is skewed per column, psum per row.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            acc_in[r][0] = pp_q[r][r];
            for (int c = 1; c < COLS; c++) acc_in[r][c] = acc_q[r][c-1];
            for (int c = 0; c < COLS; c++)
                acc_d[r][c] = acc_add(acc_in[r][c],
                                      mac_term(w_q[r][c], xp_q[r+c][c], CW'(c) < k_q));
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int d = 0; d < XD; d++)
                for (int c = 0; c < COLS; c++) xp_q[d][c] <= '0;
            for (int d = 0; d < ROWS; d++)
                for (int r = 0; r < ROWS; r++) begin
                    pp_q[d][r] <= '0;
                    dk_q[d][r] <= '0;
                end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) acc_q[r][c] <= '0;
            vp_q        <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else if (run) begin
            for (int c = 0; c < COLS; c++)
                xp_q[0][c] <= accept ? x_data_i[(COLS-1-c)*DW +: DW] : '0;
            for (int d = 1; d < XD; d++)
                for (int c = 0; c < COLS; c++) xp_q[d][c] <= xp_q[d-1][c];
            for (int r = 0; r < ROWS; r++) begin
                pp_q[0][r] <= (accept && psum_en_i) ? psum_i[(ROWS-1-r)*AW +: AW] : '0;
                dk_q[0][r] <= acc_q[r][COLS-1];
            end
            for (int d = 1; d < ROWS; d++)
                for (int r = 0; r < ROWS; r++) begin
                    pp_q[d][r] <= pp_q[d-1][r];
                    dk_q[d][r] <= dk_q[d-1][r];
                end
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) acc_q[r][c] <= acc_d[r][c];
            vp_q        <= {vp_q[LAT-2:0], accept};
            out_valid_q <= vp_q[LAT-1];
            // Row r is delayed ROWS-r more steps so all rows of a vector land together.
            if (vp_q[LAT-1]) begin
                for (int r = 0; r < ROWS; r++) y_q[(ROWS-1-r)*AW +: AW] <= dk_q[ROWS-1-r][r];
            end
        end
    end

    assign y_o         = y_q;
    assign out_valid_o = out_valid_q & run;
    assign w_ready_o   = (state_q == ST_READY);
    assign busy_o      = (inflight_q != '0);
    assign err_o       = err_q;

endmodule

// File: tb/tb_ws_mac_array_param.sv
// Scoreboard bench for ws_mac_array_param (4x4, DW=8, AW=16): stimulus pushes expected results,
// a negedge monitor pops and compares value and arrival cycle.
`timescale 1ns/1ps
module tb_ws_mac_array_param;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int LAT  = ROWS + COLS + 1;

    logic                 CLK, RSTN;
    logic                 w_start_i, w_valid_i, x_valid_i, psum_en_i, hold_i;
    logic [2:0]           cfg_cols_i;
    logic [COLS*DW-1:0]   w_data_i, x_data_i;
    logic [ROWS*AW-1:0]   psum_i, y_o;
    logic                 out_valid_o, w_ready_o, busy_o, err_o;

    typedef struct {
        logic [ROWS*AW-1:0] y;
        int                 due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    ws_mac_array_param #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .w_start_i(w_start_i), .cfg_cols_i(cfg_cols_i),
        .w_valid_i(w_valid_i), .w_data_i(w_data_i),
        .x_valid_i(x_valid_i), .x_data_i(x_data_i),
        .psum_en_i(psum_en_i), .psum_i(psum_i), .hold_i(hold_i),
        .y_o(y_o), .out_valid_o(out_valid_o), .w_ready_o(w_ready_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTN && out_valid_o) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", out_valid_o, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("y", y_o, mon_e.y);
                check("out_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    function automatic logic [31:0] px(input int a, input int b, input int c, input int d);
        return {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    function automatic logic [63:0] py(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    task automatic load(input logic [2:0] k, input logic [127:0] wall);
        w_start_i  = 1'b1;
        cfg_cols_i = k;
        step();
        w_start_i = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            w_valid_i = 1'b1;
            w_data_i  = wall[(ROWS-1-r)*32 +: 32];
            step();
        end
        w_valid_i = 1'b0;
        w_data_i  = '0;
    endtask

    // extra: hold cycles expected between accept and output
    task automatic send(input logic [31:0] x, input logic pen, input logic [63:0] ps,
                        input logic [63:0] y, input int extra);
        exp_t e;
        x_valid_i = 1'b1;
        x_data_i  = x;
        psum_en_i = pen;
        psum_i    = ps;
        e.y   = y;
        e.due = cyc + 1 + LAT + extra;
        sb.push_back(e);
        step();
        x_valid_i = 1'b0;
        psum_en_i = 1'b0;
        psum_i    = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_queue_empty", sb.size(), 0);
        step();
        check("busy_after_drain", busy_o, 1'b0);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        sb.delete();
        idle(2);
        RSTN = 1'b1;
    endtask

    initial begin
        RSTN = 1'b0;
        {w_start_i, w_valid_i, x_valid_i, psum_en_i, hold_i} = '0;
        cfg_cols_i = '0;
        w_data_i   = '0;
        x_data_i   = '0;
        psum_i     = '0;
        idle(3);
        RSTN = 1'b1;

        check("rst_y", y_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_w_ready", w_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);

        // identity weights; second vector carries a psum that must be ignored
        load(3'd4, {px(1,0,0,0), px(0,1,0,0), px(0,0,1,0), px(0,0,0,1)});
        check("w_ready_after_load", w_ready_o, 1'b1);
        send(px(1,2,3,4), 1'b0, '0, py(1,2,3,4), 0);
        check("busy_in_flight", busy_o, 1'b1);
        send(px(4,3,2,1), 1'b0, py(5,5,5,5), py(4,3,2,1), 0);
        drain();

        // asynchronous reset with two vectors in flight
        send(px(7,7,7,7), 1'b0, '0, py(7,7,7,7), 0);
        send(px(9,9,9,9), 1'b0, '0, py(9,9,9,9), 0);
        idle(3);
        #2 RSTN = 1'b0;
        #1;
        check("midrst_y", y_o, 0);
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_w_ready", w_ready_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_err", err_o, 0);
        sb.delete();
        idle(2);
        RSTN = 1'b1;
        idle(15);
        check("w_ready_after_reset", w_ready_o, 1'b0);

        // all-ones weights, back-to-back stream with a 2-cycle hold mid-stream
        load(3'd4, {4{32'h01010101}});
        send(px(1,1,1,1), 1'b0, '0, py(4,4,4,4), 2);
        send(px(2,2,2,2), 1'b0, '0, py(8,8,8,8), 2);
        hold_i    = 1'b1;
        x_valid_i = 1'b1;
        x_data_i  = px(3,3,3,3);
        idle(2);
        hold_i = 1'b0;
        send(px(3,3,3,3), 1'b0, '0, py(12,12,12,12), 0);
        send(px(4,4,4,4), 1'b0, '0, py(16,16,16,16), 0);
        drain();
        check("err_after_hold", err_o, 1'b0);

        // active-column selection, including out-of-range settings meaning all columns
        load(3'd2, {4{32'h01010101}});
        send(px(5,5,9,9), 1'b0, '0, py(10,10,10,10), 0);
        drain();
        load(3'd0, {4{32'h01010101}});
        send(px(1,2,3,5), 1'b0, '0, py(11,11,11,11), 0);
        drain();
        load(3'd7, {4{32'h01010101}});
        send(px(2,2,2,2), 1'b0, '0, py(8,8,8,8), 0);
        drain();

        // extremes: -128*-128 x4 and 127*-128 x4
        load(3'd4, {4{32'h80808080}});
`ifdef WS_ARRAY_SAT_EN
        send(32'h80808080, 1'b1, '0, {4{16'h7fff}}, 0);
        send(32'h7f7f7f7f, 1'b0, '0, {4{16'h8000}}, 0);
`else
        send(32'h80808080, 1'b1, '0, {4{16'h0000}}, 0);
        send(32'h7f7f7f7f, 1'b0, '0, {4{16'h0200}}, 0);
`endif
        drain();
        check("err_clean_run", err_o, 1'b0);

        // vector before any weight load is dropped and flags an error
        do_reset();
        x_valid_i = 1'b1;
        x_data_i  = px(1,1,1,1);
        step();
        x_valid_i = 1'b0;
        check("err_x_before_load", err_o, 1'b1);
        check("busy_dropped_vec", busy_o, 1'b0);
        idle(15);

        // zero weights, preload partial sum only
        load(3'd4, '0);
        send(px(3,3,3,3), 1'b1, py(-7,-7,-7,-7), py(-7,-7,-7,-7), 0);
        drain();
        check("err_sticky", err_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
